control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- IRval  input  32  instruction register contents; op=[31:27], ra=[26:23], rb=[22:19], rc=[18:15].
- CON  input  1  branch-condition flag, sampled in T6 of br.
- PCout, PCin, IncPc, MARin, MDRin, MDRout, IRin, Yin  output  1 each  datapath strobes.
- Zin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, HIout, LOin, LOout  output  1 each  Z/HI/LO strobes.
- read, write  output  1 each  RAM strobes.
- Rin, Rout, GRA, GRB, GRC, BAout, Cout  output  1 each  register-select strobes.
- InPortout, OutPortin  output  1 each  I/O strobes.
- mdr_read  output  2  MDR source: 00=bus, 01=memory, 10=immediate, 11=zero.
- control  output  4  ALU op: ADD 0000, SUB 0001, AND 0010, OR 0011, SHR 0100, SHL 0101, ROR 0110, ROL 0111, MUL 1000, DIV 1001, NEG 1010, NOT 1011.
- run  output  1  high in every state except IDLE and HALT.
- tstate  output  3  current T-step, for debug.

Function
REQ-002 States SHALL be IDLE, T0..T7, HALT; all outputs SHALL be Moore-decoded from state and IRval; every unlisted output SHALL be 0 in every step.
REQ-003 IDLE SHALL drive all outputs 0 and SHALL go to T0 on the first clock with reset low.
REQ-004 Fetch SHALL run in three steps:
- T0: PCout, MARin, IncPc, Zin, Zlowin.
- T1: Zlowout, PCin, read, mdr_read=01, MDRin.
- T2: MDRout, IRin.
REQ-005 Opcodes SHALL be: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, br 10010, jr 10011, in 10101, out 10110, mfhi 10111, mflo 11000, nop 11001, halt 11010.
REQ-006 R-type ops (add..rol) SHALL sequence:
- T3: GRB, Rout, Yin.
- T4: GRC, Rout, control=op, Zin, Zlowin.
- T5: Zlowout, GRA, Rin.
- then T0.
REQ-007 addi/andi/ori SHALL follow REQ-006, except T4 asserts Cout instead of GRC/Rout, with control=ADD/AND/OR.
REQ-008 mul/div SHALL sequence:
- T3: GRA, Rout, Yin.
- T4: GRB, Rout, control, Zin, Zlowin, Zhighin.
- T5: Zlowout, LOin.
- T6: Zhighout, HIin.
- then T0.
REQ-009 neg/not SHALL sequence:
- T3: GRB, Rout, control, Zin, Zlowin.
- T4: Zlowout, GRA, Rin.
- then T0.
REQ-010 ld, ldi and st SHALL share T3 (GRB, BAout, Yin) and T4 (Cout, control=ADD, Zin, Zlowin).
REQ-011 ldi SHALL then run T5: Zlowout, GRA, Rin, then T0.
REQ-012 ld SHALL then run:
- T5: Zlowout, MARin.
- T6: read, mdr_read=01, MDRin.
- T7: MDRout, GRA, Rin.
- then T0.
REQ-013 st SHALL then run:
- T5: Zlowout, MARin.
- T6: GRA, Rout, mdr_read=00, MDRin.
- T7: write.
- then T0.
REQ-014 br SHALL sequence:
- T3: GRA, Rout (CON evaluated by datapath).
- T4: PCout, Yin.
- T5: Cout, control=ADD, Zin, Zlowin.
- T6: if CON=1, Zlowout and PCin; if CON=0, no strobes.
- then T0.
REQ-015 Single-step ops SHALL run T3 then T0:
- jr: GRA, Rout, PCin.
- in: InPortout, GRA, Rin.
- out: GRA, Rout, OutPortin.
- mfhi: HIout, GRA, Rin.
- mflo: LOout, GRA, Rin.
- nop and undefined opcodes: no strobes.
REQ-016 halt SHALL enter HALT after T2; HALT SHALL drive all outputs 0 and hold until reset.
REQ-017 tstate SHALL equal the T index in T0..T7 and 0 in IDLE/HALT; no opcode SHALL exceed T7.
REQ-018 read and write SHALL never be asserted in the same cycle, and at most one bus-driving strobe (PCout, Zlowout, Zhighout, MDRout, Rout, HIout, LOout, InPortout, Cout) SHALL be high in any cycle.

Reset
REQ-019 reset high at a clock edge SHALL force IDLE, run=0, tstate=0 and all strobes 0 from the next cycle, regardless of the current state, including mid-instruction and HALT.

Verification
REQ-020 Reset release, IRval=0x18918000 (add r1,r2,r3) -> IDLE, T0..T5 strobes per REQ-004/006 with control=0000 at T4, back in T0 at cycle 8.
REQ-021 IRval=0x00918005 (ld r1,5(r2)) -> T6 read=1 and mdr_read=01; T7 MDRout+GRA+Rin; total 8 steps.
REQ-022 br with CON=0 and with CON=1 -> T6 PCin=0 and PCin=1 respectively; both return to T0.
REQ-023 IRval=0xD0000000 (halt) -> HALT after T2, run=0 for 20 cycles; reset -> IDLE, then T0.
REQ-024 reset asserted at T4 of mul -> next cycle IDLE with HIin=LOin=0; the bench SHALL check REQ-018 every cycle.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired T-step control sequencer: fetch in T0..T2, then opcode-specific execute steps up to T7.
// Strobes are Moore-decoded from the current step and IRval. Each step lasts one cycle.
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IRval,
    input  logic        CON,
    output logic        PCout, PCin, IncPc, MARin, MDRin, MDRout, IRin, Yin,
    output logic        Zin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, HIout, LOin, LOout,
    output logic        read, write,
    output logic        Rin, Rout, GRA, GRB, GRC, BAout, Cout,
    output logic        InPortout, OutPortin,
    output logic [1:0]  mdr_read,
    output logic [3:0]  control,
    output logic        run,
    output logic [2:0]  tstate
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110, OP_SHR  = 5'b00111, OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001, OP_ROL  = 5'b01010, OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100, OP_ORI  = 5'b01101, OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111, OP_NEG  = 5'b10000, OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010, OP_JR   = 5'b10011, OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110, OP_MFHI = 5'b10111, OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    state_t     state_q, state_d;
    logic [4:0] op;
    logic       unused_fields;
    logic       is_rtype, is_imm, is_muldiv, is_negnot;
    logic [3:0] alu_op;
    logic [2:0] last_t;

    assign op            = IRval[31:27];
    assign unused_fields = ^IRval[26:0];

    assign is_rtype  = (op >= OP_ADD) && (op <= OP_ROL);
    assign is_imm    = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    assign is_negnot = (op == OP_NEG) || (op == OP_NOT);

    always_comb begin
        alu_op = ALU_ADD;
        case (op)
            OP_SUB:           alu_op = 4'b0001;
            OP_AND, OP_ANDI:  alu_op = 4'b0010;
            OP_OR, OP_ORI:    alu_op = 4'b0011;
            OP_SHR:           alu_op = 4'b0100;
            OP_SHL:           alu_op = 4'b0101;
            OP_ROR:           alu_op = 4'b0110;
            OP_ROL:           alu_op = 4'b0111;
            OP_MUL:           alu_op = 4'b1000;
            OP_DIV:           alu_op = 4'b1001;
            OP_NEG:           alu_op = 4'b1010;
            OP_NOT:           alu_op = 4'b1011;
            default:          alu_op = ALU_ADD;
        endcase
    end

    // Final execute step per opcode; single-step, nop and undefined opcodes end at T3.
    always_comb begin
        last_t = 3'd3;
        if (is_rtype || is_imm || op == OP_LDI)     last_t = 3'd5;
        else if (op == OP_LD || op == OP_ST)        last_t = 3'd7;
        else if (is_muldiv || op == OP_BR)          last_t = 3'd6;
        else if (is_negnot)                         last_t = 3'd4;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = (op == OP_HALT) ? S_HALT : S_T3;
            S_T3:    state_d = (last_t == 3'd3) ? S_T0 : S_T4;
            S_T4:    state_d = (last_t == 3'd4) ? S_T0 : S_T5;
            S_T5:    state_d = (last_t == 3'd5) ? S_T0 : S_T6;
            S_T6:    state_d = (last_t == 3'd6) ? S_T0 : S_T7;
            S_T7:    state_d = S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        {PCout, PCin, IncPc, MARin, MDRin, MDRout, IRin, Yin} = '0;
        {Zin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, HIout, LOin, LOout} = '0;
        {read, write, Rin, Rout, GRA, GRB, GRC, BAout, Cout} = '0;
        {InPortout, OutPortin} = '0;
        mdr_read = 2'b00;
        control  = ALU_ADD;
        run      = (state_q != S_IDLE) && (state_q != S_HALT);
        tstate   = 3'd0;
        case (state_q)
            S_T0: begin
                tstate = 3'd0;
                {PCout, MARin, IncPc, Zin, Zlowin} = '1;
            end
            S_T1: begin
                tstate   = 3'd1;
                {Zlowout, PCin, read, MDRin} = '1;
                mdr_read = 2'b01;
            end
            S_T2: begin
                tstate = 3'd2;
                {MDRout, IRin} = '1;
            end
            S_T3: begin
                tstate = 3'd3;
                if (is_rtype || is_imm) {GRB, Rout, Yin} = '1;
                else if (is_muldiv)     {GRA, Rout, Yin} = '1;
                else if (is_negnot) begin
                    {GRB, Rout, Zin, Zlowin} = '1;
                    control = alu_op;
                end
                else if (op == OP_LD || op == OP_LDI || op == OP_ST) {GRB, BAout, Yin} = '1;
                else if (op == OP_BR)   {GRA, Rout} = '1;
                else if (op == OP_JR)   {GRA, Rout, PCin} = '1;
                else if (op == OP_IN)   {InPortout, GRA, Rin} = '1;
                else if (op == OP_OUT)  {GRA, Rout, OutPortin} = '1;
                else if (op == OP_MFHI) {HIout, GRA, Rin} = '1;
                else if (op == OP_MFLO) {LOout, GRA, Rin} = '1;
            end
            S_T4: begin
                tstate = 3'd4;
                if (is_rtype) begin
                    {GRC, Rout, Zin, Zlowin} = '1;
                    control = alu_op;
                end
                else if (is_imm) begin
                    {Cout, Zin, Zlowin} = '1;
                    control = alu_op;
                end
                else if (is_muldiv) begin
                    {GRB, Rout, Zin, Zlowin, Zhighin} = '1;
                    control = alu_op;
                end
                else if (is_negnot) {Zlowout, GRA, Rin} = '1;
                else if (op == OP_LD || op == OP_LDI || op == OP_ST) {Cout, Zin, Zlowin} = '1;
                else if (op == OP_BR) {PCout, Yin} = '1;
            end
            S_T5: begin
                tstate = 3'd5;
                if (is_rtype || is_imm || op == OP_LDI)  {Zlowout, GRA, Rin} = '1;
                else if (is_muldiv)                      {Zlowout, LOin} = '1;
                else if (op == OP_LD || op == OP_ST)     {Zlowout, MARin} = '1;
                else if (op == OP_BR)                    {Cout, Zin, Zlowin} = '1;
            end
            S_T6: begin
                tstate = 3'd6;
                if (is_muldiv) {Zhighout, HIin} = '1;
                else if (op == OP_LD) begin
                    {read, MDRin} = '1;
                    mdr_read = 2'b01;
                end
                else if (op == OP_ST)         {GRA, Rout, MDRin} = '1;
                else if (op == OP_BR && CON)  {Zlowout, PCin} = '1;
            end
            S_T7: begin
                tstate = 3'd7;
                if (op == OP_LD)      {MDRout, GRA, Rin} = '1;
                else if (op == OP_ST) write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: each instruction expands into an expected per-step strobe program.
module tb_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, CON;
    logic [31:0] IRval;
    logic PCout, PCin, IncPc, MARin, MDRin, MDRout, IRin, Yin;
    logic Zin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, HIout, LOin, LOout;
    logic read, write, Rin, Rout, GRA, GRB, GRC, BAout, Cout, InPortout, OutPortin;
    logic [1:0] mdr_read;
    logic [3:0] control;
    logic       run;
    logic [2:0] tstate;

    control_sequencer dut (
        .clk(clk), .reset(reset), .IRval(IRval), .CON(CON),
        .PCout(PCout), .PCin(PCin), .IncPc(IncPc), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .read(read), .write(write),
        .Rin(Rin), .Rout(Rout), .GRA(GRA), .GRB(GRB), .GRC(GRC), .BAout(BAout), .Cout(Cout),
        .InPortout(InPortout), .OutPortin(OutPortin),
        .mdr_read(mdr_read), .control(control), .run(run), .tstate(tstate)
    );

    logic [27:0] obs_s;
    assign obs_s = {OutPortin, InPortout, Cout, BAout, GRC, GRB, GRA, Rout, Rin, write, read,
                    LOout, LOin, HIout, HIin, Zhighout, Zlowout, Zhighin, Zlowin, Zin,
                    Yin, IRin, MDRout, MDRin, MARin, IncPc, PCin, PCout};

    localparam logic [27:0] M_PCOUT  = 28'h1 << 0,  M_PCIN    = 28'h1 << 1,  M_INCPC   = 28'h1 << 2;
    localparam logic [27:0] M_MARIN  = 28'h1 << 3,  M_MDRIN   = 28'h1 << 4,  M_MDROUT  = 28'h1 << 5;
    localparam logic [27:0] M_IRIN   = 28'h1 << 6,  M_YIN     = 28'h1 << 7,  M_ZIN     = 28'h1 << 8;
    localparam logic [27:0] M_ZLOWIN = 28'h1 << 9,  M_ZHIGHIN = 28'h1 << 10, M_ZLOWOUT = 28'h1 << 11;
    localparam logic [27:0] M_ZHIOUT = 28'h1 << 12, M_HIIN    = 28'h1 << 13, M_HIOUT   = 28'h1 << 14;
    localparam logic [27:0] M_LOIN   = 28'h1 << 15, M_LOOUT   = 28'h1 << 16, M_READ    = 28'h1 << 17;
    localparam logic [27:0] M_WRITE  = 28'h1 << 18, M_RIN     = 28'h1 << 19, M_ROUT    = 28'h1 << 20;
    localparam logic [27:0] M_GRA    = 28'h1 << 21, M_GRB     = 28'h1 << 22, M_GRC     = 28'h1 << 23;
    localparam logic [27:0] M_BAOUT  = 28'h1 << 24, M_COUT    = 28'h1 << 25, M_INPORT  = 28'h1 << 26;
    localparam logic [27:0] M_OUTPORT = 28'h1 << 27;

    typedef struct packed {
        logic [27:0] s;
        logic [1:0]  mdr;
        logic [3:0]  ctl;
        logic [2:0]  t;
        logic        run;
    } step_t;

    step_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_bus(input string tag);
        logic [8:0] drv;
        drv = {PCout, Zlowout, Zhighout, MDRout, Rout, HIout, LOout, InPortout, Cout};
        check_eq({tag, "_rd_wr_excl"}, 32'(read & write), 32'd0);
        check_eq({tag, "_one_bus_driver"}, 32'($countones(drv) <= 1), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_strobes"}, 32'(obs_s), 32'd0);
        check_eq({tag, "_mdr_ctl"}, 32'({mdr_read, control}), 32'd0);
        check_eq({tag, "_run"}, 32'(run), 32'd0);
        check_eq({tag, "_tstate"}, 32'(tstate), 32'd0);
        check_bus(tag);
    endtask

    function automatic void add_t(input logic [27:0] s, input logic [1:0] mdr, input logic [3:0] ctl);
        step_t st;
        st.s = s; st.mdr = mdr; st.ctl = ctl; st.t = 3'(exp_q.size()); st.run = 1'b1;
        exp_q.push_back(st);
    endfunction

    // Expected step program for one instruction, straight from the opcode description.
    function automatic void build_prog(input int op, input logic con);
        step_t z;
        z = '0;
        exp_q.delete();
        add_t(M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_ZLOWIN, 2'b00, 4'd0);
        add_t(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 2'b01, 4'd0);
        add_t(M_MDROUT | M_IRIN, 2'b00, 4'd0);
        if (op >= 3 && op <= 13) begin
            add_t(M_GRB | M_ROUT | M_YIN, 2'b00, 4'd0);
            if (op <= 10) add_t(M_GRC | M_ROUT | M_ZIN | M_ZLOWIN, 2'b00, 4'(op - 3));
            else          add_t(M_COUT | M_ZIN | M_ZLOWIN, 2'b00, (op == 11) ? 4'd0 : (op == 12) ? 4'd2 : 4'd3);
            add_t(M_ZLOWOUT | M_GRA | M_RIN, 2'b00, 4'd0);
        end else if (op == 14 || op == 15) begin
            add_t(M_GRA | M_ROUT | M_YIN, 2'b00, 4'd0);
            add_t(M_GRB | M_ROUT | M_ZIN | M_ZLOWIN | M_ZHIGHIN, 2'b00, 4'(op - 6));
            add_t(M_ZLOWOUT | M_LOIN, 2'b00, 4'd0);
            add_t(M_ZHIOUT | M_HIIN, 2'b00, 4'd0);
        end else if (op == 16 || op == 17) begin
            add_t(M_GRB | M_ROUT | M_ZIN | M_ZLOWIN, 2'b00, 4'(op - 6));
            add_t(M_ZLOWOUT | M_GRA | M_RIN, 2'b00, 4'd0);
        end else if (op <= 2) begin
            add_t(M_GRB | M_BAOUT | M_YIN, 2'b00, 4'd0);
            add_t(M_COUT | M_ZIN | M_ZLOWIN, 2'b00, 4'd0);
            if (op == 1) add_t(M_ZLOWOUT | M_GRA | M_RIN, 2'b00, 4'd0);
            else begin
                add_t(M_ZLOWOUT | M_MARIN, 2'b00, 4'd0);
                if (op == 0) begin
                    add_t(M_READ | M_MDRIN, 2'b01, 4'd0);
                    add_t(M_MDROUT | M_GRA | M_RIN, 2'b00, 4'd0);
                end else begin
                    add_t(M_GRA | M_ROUT | M_MDRIN, 2'b00, 4'd0);
                    add_t(M_WRITE, 2'b00, 4'd0);
                end
            end
        end else if (op == 18) begin
            add_t(M_GRA | M_ROUT, 2'b00, 4'd0);
            add_t(M_PCOUT | M_YIN, 2'b00, 4'd0);
            add_t(M_COUT | M_ZIN | M_ZLOWIN, 2'b00, 4'd0);
            add_t(con ? (M_ZLOWOUT | M_PCIN) : 28'd0, 2'b00, 4'd0);
        end else if (op == 26) begin
            for (int k = 0; k < 20; k++) exp_q.push_back(z);
        end else begin
            case (op)
                19:      add_t(M_GRA | M_ROUT | M_PCIN, 2'b00, 4'd0);
                21:      add_t(M_INPORT | M_GRA | M_RIN, 2'b00, 4'd0);
                22:      add_t(M_GRA | M_ROUT | M_OUTPORT, 2'b00, 4'd0);
                23:      add_t(M_HIOUT | M_GRA | M_RIN, 2'b00, 4'd0);
                24:      add_t(M_LOOUT | M_GRA | M_RIN, 2'b00, 4'd0);
                default: add_t(28'd0, 2'b00, 4'd0);
            endcase
        end
    endfunction

    // Runs one instruction; IRval/CON change only after T0 is seen. abort_at >= 0 pulses reset after that step.
    task automatic run_instr(input logic [31:0] ir, input logic con, input int abort_at);
        int    op;
        string tg;
        op = int'(ir[31:27]);
        build_prog(op, con);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            tg = $sformatf("op%0d_step%0d", op, i);
            check_eq({tg, "_strobes"}, 32'(obs_s), 32'(exp_q[i].s));
            check_eq({tg, "_mdr_read"}, 32'(mdr_read), 32'(exp_q[i].mdr));
            check_eq({tg, "_control"}, 32'(control), 32'(exp_q[i].ctl));
            check_eq({tg, "_tstate"}, 32'(tstate), 32'(exp_q[i].t));
            check_eq({tg, "_run"}, 32'(run), 32'(exp_q[i].run));
            check_bus(tg);
            if (i == 0) begin
                IRval = ir;
                CON   = con;
            end
            if (i == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                check_idle($sformatf("op%0d_abort%0d", op, i));
                reset = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] ir;
        int          op, ab;
        reset = 1'b1;
        IRval = 32'd0;
        CON   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;

        run_instr(32'h18918000, 1'b0, -1);           // add r1,r2,r3
        run_instr(32'h00918005, 1'b0, -1);           // ld r1,5(r2)
        run_instr({5'b10010, 27'h0123456}, 1'b0, -1); // br, not taken
        run_instr({5'b10010, 27'h0123456}, 1'b1, -1); // br, taken
        run_instr({5'b01110, 27'h0918000}, 1'b0, 4);  // mul, reset at T4
        run_instr(32'hD0000000, 1'b0, -1);           // halt, 20 cycles in HALT
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle("halt_reset");
        reset = 1'b0;

        for (int n = 0; n < 120; n++) begin
            op = $urandom_range(0, 31);
            if (op == 26 && $urandom_range(0, 3) != 0) op = 25;
            ir = {op[4:0], 27'($urandom)};
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
            run_instr(ir, 1'($urandom_range(0, 1)), ab);
            if (op == 26) begin
                reset = 1'b1;
                @(posedge clk); #1;
                check_idle("rand_halt_reset");
                reset = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
